// File: rtl/mem_seg_pkg.sv
// mem_seg_pkg
//   Shared definitions for the MEM pipeline stage: memory opcodes, FSM state
//   type, access-size type and opcode decode helpers.
package mem_seg_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } acc_size_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Only meaningful for memory opcodes; anything else reports WORD.
  function automatic acc_size_t acc_size(input logic [5:0] op);
    acc_size_t s;
    case (op)
      OP_LB, OP_LBU, OP_SB: s = BYTE;
      OP_LH, OP_LHU, OP_SH: s = HALF;
      default:              s = WORD;
    endcase
    return s;
  endfunction

  function automatic logic is_signed_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational lane steering for byte/halfword/word accesses.
//   Ports:
//     size_i     access size
//     sign_i     1 = sign-extend load data
//     addr_i     address bits [1:0]
//     b_i        store data (rt value)
//     rdata_i    raw memory read word
//     be_o       little-endian byte enables
//     wdata_o    store data replicated across lanes
//     ldata_o    selected and extended load data
//     misalign_o access not naturally aligned for its size
module mem_lane_align
  import mem_seg_pkg::*;
(
  input  acc_size_t   size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] b_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = b_i;
    ldata_o    = rdata_i;
    misalign_o = 1'b0;
    case (size_i)
      BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{b_i[7:0]}};
        ldata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{b_i[15:0]}};
        ldata_o    = {{16{sign_i & half_sel[15]}}, half_sel};
        misalign_o = addr_i[0];
      end
      default: begin
        misalign_o = |addr_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_seg_hs.sv
// mem_seg_hs
//   Handshaked MEM stage between EX/MEM and MEM/WB. Issues loads/stores to a
//   variable-latency data memory, flags misaligned accesses, aborts on bus
//   timeout and stalls upstream (in_ready low) while an access is pending.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready to accept; non-memory/misaligned ops complete directly
//   BUSY  | dm_req held, waiting for dm_ack or the timeout
//
//   Ports:
//     clk, rst                    clock, async active-low reset
//     in_valid / in_ready         upstream handshake
//     B_i, ALUo_In_i, IR_i        EX/MEM operands
//     out_valid, ALUo_Out, LMD,
//     IR_Out, exc_align, exc_bus  MEM/WB results (held between completions)
//     dm_*                        data-memory port
module mem_seg_hs
  import mem_seg_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       B_i,
  input  logic [31:0]       ALUo_In_i,
  input  logic [31:0]       IR_i,
  output logic              out_valid,
  output logic [31:0]       ALUo_Out,
  output logic [31:0]       LMD,
  output logic [31:0]       IR_Out,
  output logic              exc_align,
  output logic              exc_bus,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires on the edge where the counter would step onto TIMEOUT,
  // so dm_req is high for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        b_q, b_d;
  logic               out_valid_q, out_valid_d;
  logic               exc_align_q, exc_align_d;
  logic               exc_bus_q, exc_bus_d;
  logic [31:0]        lmd_q, lmd_d;
  logic [31:0]        alu_out_q, alu_out_d;
  logic [31:0]        ir_out_q, ir_out_d;

  logic               busy;
  logic [5:0]         lane_op;
  logic [1:0]         lane_addr;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane_ldata;
  logic               lane_mis;
  logic               mem_in;
  logic               timeout_hit;

  assign busy = (state_q == BUSY);

  // One lane aligner serves both phases: in IDLE it looks at the incoming
  // instruction (only the misalign flag matters), in BUSY at the latched one.
  assign lane_op   = busy ? ir_q[31:26] : IR_i[31:26];
  assign lane_addr = busy ? alu_q[1:0]  : ALUo_In_i[1:0];

  mem_lane_align u_lane (
    .size_i     (acc_size(lane_op)),
    .sign_i     (is_signed_load(lane_op)),
    .addr_i     (lane_addr),
    .b_i        (b_q),
    .rdata_i    (dm_rdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .ldata_o    (lane_ldata),
    .misalign_o (lane_mis)
  );

  assign mem_in      = is_load(IR_i[31:26]) | is_store(IR_i[31:26]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_d        = ir_q;
    alu_d       = alu_q;
    b_d         = b_q;
    out_valid_d = 1'b0;
    exc_align_d = 1'b0;
    exc_bus_d   = 1'b0;
    lmd_d       = lmd_q;
    alu_out_d   = alu_out_q;
    ir_out_d    = ir_out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ir_d  = IR_i;
          alu_d = ALUo_In_i;
          b_d   = B_i;
          if (mem_in && !lane_mis) begin
            state_d = BUSY;
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            exc_align_d = mem_in;
            lmd_d       = '0;
            alu_out_d   = ALUo_In_i;
            ir_out_d    = IR_i;
          end
        end
      end
      BUSY: begin
        if (dm_ack) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          lmd_d       = is_load(ir_q[31:26]) ? lane_ldata : '0;
          alu_out_d   = alu_q;
          ir_out_d    = ir_q;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          exc_bus_d   = 1'b1;
          lmd_d       = '0;
          alu_out_d   = alu_q;
          ir_out_d    = ir_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ir_q        <= '0;
      alu_q       <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      exc_align_q <= 1'b0;
      exc_bus_q   <= 1'b0;
      lmd_q       <= '0;
      alu_out_q   <= '0;
      ir_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ir_q        <= ir_d;
      alu_q       <= alu_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      exc_align_q <= exc_align_d;
      exc_bus_q   <= exc_bus_d;
      lmd_q       <= lmd_d;
      alu_out_q   <= alu_out_d;
      ir_out_q    <= ir_out_d;
    end
  end

  assign in_ready  = ~busy;
  assign out_valid = out_valid_q;
  assign exc_align = exc_align_q;
  assign exc_bus   = exc_bus_q;
  assign LMD       = lmd_q;
  assign ALUo_Out  = alu_out_q;
  assign IR_Out    = ir_out_q;

  // Memory-side outputs are quiet unless a request is outstanding; while it
  // is, they derive only from latched state and therefore stay stable.
  assign dm_req   = busy;
  assign dm_we    = busy & is_store(ir_q[31:26]);
  assign dm_be    = busy ? lane_be : 4'b0000;
  assign dm_addr  = busy ? {alu_q[ADDR_W-1:2], 2'b00} : '0;
  assign dm_wdata = busy ? lane_wdata : 32'h0;

endmodule
